// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box table and key-schedule round constants.
package aes_pkg;

  // Forward S-box, index = input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Key-schedule round constants for rounds 1..10 (index 0 = round 1).
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sbox_lut.sv
// Purely combinational forward S-box lookup.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Constant-table lookup; every index is defined so no X can escape.
  always_comb begin
    out_byte = SBOX[in_byte];
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box with optional one-cycle output register.
// REG_OUT=1: registered, latency 1. REG_OUT=0: combinational, latency 0.
module aes_sbox
  import aes_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  output logic [7:0] out_byte
);

  logic [7:0] lut_byte;

  aes_sbox_lut u_lut (
    .in_byte  (in_byte),
    .out_byte (lut_byte)
  );

  if (REG_OUT) begin : g_reg
    logic [7:0] out_byte_d, out_byte_q;
    logic       out_valid_d, out_valid_q;

    // Next-state: capture a new byte only when qualified, otherwise hold.
    always_comb begin
      out_byte_d  = out_byte_q;
      out_valid_d = in_valid;
      if (in_valid) begin
        out_byte_d = lut_byte;
      end
    end

    // Output register; reset drops any byte presented on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_byte_q  <= 8'h00;
        out_valid_q <= 1'b0;
      end else begin
        out_byte_q  <= out_byte_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
  end else begin : g_comb
    // Bypass: data is always the lookup; only the qualifier sees reset.
    assign out_byte  = lut_byte;
    assign out_valid = in_valid & ~rst;
  end

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox: registered sweep, reset, gaps,
// combinational word lookup and a key-expansion run through the DUT.
module tb_aes_sbox;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       out_valid;
  logic [7:0] out_byte;

  logic       comb_vld = 1'b0;
  logic [7:0] comb_in  [4];
  logic [7:0] comb_out [4];
  logic       comb_vout[4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_sbox #(.REG_OUT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_byte  (out_byte)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_comb_dut
    aes_sbox #(.REG_OUT(1'b0)) u_comb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (comb_vld),
      .in_byte   (comb_in[gi]),
      .out_valid (comb_vout[gi]),
      .out_byte  (comb_out[gi])
    );
  end

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, a);  // a^254 = a^-1, 0 -> 0
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycle model of the registered DUT, updated on each rising edge.
  logic       exp_v;
  logic [7:0] exp_b;
  logic       model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_v    <= 1'b0;
      exp_b    <= 8'h00;
      model_ok <= 1'b1;
    end else begin
      exp_v <= in_valid;
      if (in_valid) exp_b <= sbox_ref(in_byte);
    end
  end

  // Compare the registered DUT with the model every cycle, mid-period.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_out_valid", {127'd0, out_valid}, {127'd0, exp_v});
      chk("cyc_out_byte",  {120'd0, out_byte},  {120'd0, exp_b});
    end
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] b);
    @(posedge clk);
    #2;
    rst      = r;
    in_valid = v;
    in_byte  = b;
  endtask

  logic [7:0]   sweep_out [256];
  int           seen [256];
  int           vcount;
  int           distinct;
  logic [31:0]  w [4];
  logic [31:0]  tmp;
  logic [7:0]   rc;
  logic [127:0] rk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pinned by hand-computed anchors.
    chk("pin_00", {120'd0, sbox_ref(8'h00)}, 128'h63);
    chk("pin_01", {120'd0, sbox_ref(8'h01)}, 128'h7c);
    chk("pin_53", {120'd0, sbox_ref(8'h53)}, 128'hed);
    chk("pin_80", {120'd0, sbox_ref(8'h80)}, 128'hcd);
    chk("pin_ff", {120'd0, sbox_ref(8'hff)}, 128'h16);

    // Reset for two cycles.
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("rst_valid", {127'd0, out_valid}, 128'h0);
    chk("rst_byte",  {120'd0, out_byte},  128'h00);
    drive(1'b1, 1'b0, 8'h00);

    // Exhaustive sweep 00..FF on consecutive cycles.
    vcount = 0;
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) drive(1'b0, 1'b1, i[7:0]);
      else         drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      if (i > 0) begin
        sweep_out[i-1] = out_byte;
        if (out_valid) vcount++;
      end
    end
    $display("sweep: %0d valid outputs", vcount);
    chk("sweep_valid_cnt", 128'(vcount), 128'd256);
    chk("sweep_00", {120'd0, sweep_out[8'h00]}, 128'h63);
    chk("sweep_53", {120'd0, sweep_out[8'h53]}, 128'hed);
    chk("sweep_ff", {120'd0, sweep_out[8'hff]}, 128'h16);
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = 0; i < 256; i++) seen[sweep_out[i]]++;
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i] == 1) distinct++;
    chk("bijective", 128'(distinct), 128'd256);

    // Reset mid-stream with a valid 53 presented: it must be dropped.
    drive(1'b0, 1'b1, 8'h09);
    drive(1'b1, 1'b1, 8'h53);
    @(negedge clk);
    chk("pre_rst_byte", {120'd0, out_byte}, 128'h01);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("midrst_valid", {127'd0, out_valid}, 128'h0);
    chk("midrst_byte",  {120'd0, out_byte},  128'h00);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("no_ed_byte", {120'd0, out_byte}, 128'h00);
    $display("reset: byte 53 dropped check done");

    // Valid gaps: 01, idle x2, 10.
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("gap_7c",   {120'd0, out_byte}, 128'h7c);
    chk("gap_v1",   {127'd0, out_valid}, 128'h1);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("gap_hold1", {120'd0, out_byte}, 128'h7c);
    chk("gap_v0a",   {127'd0, out_valid}, 128'h0);
    drive(1'b0, 1'b1, 8'h10);
    @(negedge clk);
    chk("gap_hold2", {120'd0, out_byte}, 128'h7c);
    chk("gap_v0b",   {127'd0, out_valid}, 128'h0);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("gap_ca",   {120'd0, out_byte}, 128'hca);
    chk("gap_v2",   {127'd0, out_valid}, 128'h1);
    $display("gaps: 01 -> 7c, hold, 10 -> ca checked");

    // Combinational word lookup.
    comb_in[0] = 8'hcf; comb_in[1] = 8'h4f; comb_in[2] = 8'h3c; comb_in[3] = 8'h09;
    comb_vld = 1'b1;
    #1;
    chk("comb_word", {96'd0, comb_out[0], comb_out[1], comb_out[2], comb_out[3]}, 128'h8a84eb01);
    chk("comb_vld1", {124'd0, comb_vout[0], comb_vout[1], comb_vout[2], comb_vout[3]}, 128'hf);
    comb_vld = 1'b0;
    comb_in[0] = 8'h80;
    #1;
    chk("comb_vld0", {124'd0, comb_vout[0], comb_vout[1], comb_vout[2], comb_vout[3]}, 128'h0);
    chk("comb_novld_data", {120'd0, comb_out[0]}, 128'hcd);
    $display("comb: SubWord(cf4f3c09) checked");

    // Key expansion with SubWord from the combinational DUT instances.
    comb_vld = 1'b1;
    w[0] = 32'h2b7e1516; w[1] = 32'h28aed2a6; w[2] = 32'habf71588; w[3] = 32'h09cf4f3c;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp = {w[3][23:0], w[3][31:24]};
      comb_in[0] = tmp[31:24]; comb_in[1] = tmp[23:16];
      comb_in[2] = tmp[15:8];  comb_in[3] = tmp[7:0];
      #1;
      tmp = {comb_out[0], comb_out[1], comb_out[2], comb_out[3]} ^ {rc, 24'h0};
      w[0] = w[0] ^ tmp;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rk = {w[0], w[1], w[2], w[3]};
      $display("round %0d key %032h", r, rk);
      if (r == 1)  chk("rk1",  rk, 128'ha0fafe1788542cb123a339392a6c7605);
      if (r == 10) chk("rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rc = gmul(rc, 8'h02);
    end

    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
